sram16_wb8_ctrl: RTL

//  Wishbone-style 8-bit slave that sequences the board's external 64Kx16 async SRAM (CE/WE/OE/UB/LB).

---
 rtl/sram16_wb8_ctrl_pkg.sv | 23 ++
 rtl/sram16_wb8_ctrl_if.sv | 16 +
 rtl/sram16_wb8_ctrl_word_cache.sv | 58 +++++
 rtl/sram16_wb8_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram16_wb8_ctrl_pkg.sv
// Shared types and constants for the 8-bit Wishbone to 64Kx16 async SRAM controller.
package sram16_wb8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WSETUP = 3'd1,
        ST_WPULSE = 3'd2,
        ST_WHOLD  = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_RACK   = 3'd5
    } state_e;

    localparam int   WAIT_CYCLES_DEF = 1;
    localparam int   ADR_WIDTH_DEF   = 17;
    localparam logic LANE_LO         = 1'b0;
    localparam logic LANE_HI         = 1'b1;

    // Byte lane 1 lives on D15:8, lane 0 on D7:0.
    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sram16_wb8_ctrl_if.sv
// Wishbone-style 8-bit slave bus bundle used between the arbiter and the SRAM controller.
interface sram16_wb8_ctrl_if
    import sram16_wb8_ctrl_pkg::*;
#(
    parameter int ADR_WIDTH = ADR_WIDTH_DEF
) ();
    logic                 STB_I;
    logic                 WE_I;
    logic [ADR_WIDTH-1:0] ADR_I;
    logic [7:0]           DAT_I;
    logic [7:0]           DAT_O;
    logic                 ACK_O;

    modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
    modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
endinterface

// File: rtl/sram16_wb8_ctrl_word_cache.sv
// One-word write-through read cache; only built when SRAM16_WB8_READ_CACHE_EN is defined.
`ifdef SRAM16_WB8_READ_CACHE_EN
module sram16_wb8_ctrl_word_cache #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] lookup_adr,
    input  logic          wr_en,
    input  logic          wr_lane,
    input  logic [7:0]    wr_byte,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_adr,
    input  logic [15:0]   fill_data,
    output logic          hit,
    output logic [15:0]   rd_data
);
    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [15:0]   data_q, data_d;

    assign hit     = valid_q && (tag_q == lookup_adr);
    assign rd_data = data_q;

    // Fill on a read miss; a write to the cached word patches only its byte.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_adr;
            data_d  = fill_data;
        end else if (wr_en && hit) begin
            if (wr_lane) begin
                data_d[15:8] = wr_byte;
            end else begin
                data_d[7:0] = wr_byte;
            end
        end else begin
            data_d = data_q;
        end
    end

    // Cache state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= 16'h0000;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end
endmodule
`endif

// File: rtl/sram16_wb8_ctrl.sv
// 8-bit Wishbone slave sequencing a 64Kx16 async SRAM; all pin outputs are registered.
// Define SRAM16_WB8_READ_CACHE_EN to add a one-word read cache (single-cycle read hits).
module sram16_wb8_ctrl
    import sram16_wb8_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADR_WIDTH   = ADR_WIDTH_DEF
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    sram16_wb8_ctrl_if.slave     wb,
    output logic [ADR_WIDTH-2:0] O_sram_adr,
    output logic                 O_sram_ce_n,
    output logic                 O_sram_we_n,
    output logic                 O_sram_oe_n,
    output logic                 O_sram_ub_n,
    output logic                 O_sram_lb_n,
    output logic [15:0]          O_sram_dat,
    output logic                 O_sram_dat_oe,
    input  logic [15:0]          I_sram_dat
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADR_WIDTH-2:0] adr_q, adr_d;
    logic                 lane_q, lane_d;
    logic [7:0]           wdat_q, wdat_d;
    logic                 ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic                 ub_n_q, ub_n_d, lb_n_q, lb_n_d, dat_oe_q, dat_oe_d;
    logic                 ack_q, ack_d;
    logic [7:0]           dat_o_q, dat_o_d;
    logic                 start_s, last_s, hit_s;
    logic [15:0]          cache_word_s;

    // The ack cycle itself must not launch a second access for the same strobe.
    assign start_s = (state_q == ST_IDLE) && wb.STB_I && !ack_q;
    assign last_s  = (cnt_q == CNT_W'(WAIT_CYCLES));

`ifdef SRAM16_WB8_READ_CACHE_EN
    logic wr_en_s, fill_en_s;
    assign wr_en_s   = start_s && wb.WE_I;
    assign fill_en_s = (state_q == ST_RWAIT) && last_s;

    sram16_wb8_ctrl_word_cache #(.AW(ADR_WIDTH - 1)) u_cache (
        .clk        (CLK_I),
        .rst        (RST_I),
        .lookup_adr (wb.ADR_I[ADR_WIDTH-1:1]),
        .wr_en      (wr_en_s),
        .wr_lane    (wb.ADR_I[0]),
        .wr_byte    (wb.DAT_I),
        .fill_en    (fill_en_s),
        .fill_adr   (adr_q),
        .fill_data  (I_sram_dat),
        .hit        (hit_s),
        .rd_data    (cache_word_s)
    );
`else
    assign hit_s        = 1'b0;
    assign cache_word_s = 16'h0000;
`endif

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        lane_d   = lane_q;
        wdat_d   = wdat_q;
        ce_n_d   = ce_n_q;
        we_n_d   = we_n_q;
        oe_n_d   = oe_n_q;
        ub_n_d   = ub_n_q;
        lb_n_d   = lb_n_q;
        dat_oe_d = dat_oe_q;
        ack_d    = 1'b0;
        dat_o_d  = dat_o_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    adr_d  = wb.ADR_I[ADR_WIDTH-1:1];
                    lane_d = wb.ADR_I[0];
                    wdat_d = wb.DAT_I;
                    cnt_d  = '0;
                    if (wb.WE_I) begin
                        state_d  = ST_WSETUP;
                        ce_n_d   = 1'b0;
                        dat_oe_d = 1'b1;
                        ub_n_d   = (wb.ADR_I[0] == LANE_HI) ? 1'b0 : 1'b1;
                        lb_n_d   = (wb.ADR_I[0] == LANE_LO) ? 1'b0 : 1'b1;
                    end else if (hit_s) begin
                        ack_d   = 1'b1;
                        dat_o_d = lane_byte(cache_word_s, wb.ADR_I[0]);
                    end else begin
                        state_d = ST_RWAIT;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        ub_n_d  = 1'b0;
                        lb_n_d  = 1'b0;
                    end
                end else begin
                    ack_d = 1'b0;
                end
            end
            ST_WSETUP: begin
                state_d = ST_WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = '0;
            end
            ST_WPULSE: begin
                if (last_s) begin
                    state_d = ST_WHOLD;
                    we_n_d  = 1'b1;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WHOLD: begin
                state_d  = ST_IDLE;
                ce_n_d   = 1'b1;
                dat_oe_d = 1'b0;
                ub_n_d   = 1'b1;
                lb_n_d   = 1'b1;
            end
            ST_RWAIT: begin
                if (last_s) begin
                    state_d = ST_RACK;
                    ack_d   = 1'b1;
                    dat_o_d = lane_byte(I_sram_dat, lane_q);
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                ce_n_d   = 1'b1;
                we_n_d   = 1'b1;
                oe_n_d   = 1'b1;
                ub_n_d   = 1'b1;
                lb_n_d   = 1'b1;
                dat_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases every strobe on the next edge.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            adr_q    <= '0;
            lane_q   <= 1'b0;
            wdat_q   <= 8'h00;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            dat_oe_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_o_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            lane_q   <= lane_d;
            wdat_q   <= wdat_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            dat_oe_q <= dat_oe_d;
            ack_q    <= ack_d;
            dat_o_q  <= dat_o_d;
        end
    end

    assign O_sram_adr    = adr_q;
    assign O_sram_ce_n   = ce_n_q;
    assign O_sram_we_n   = we_n_q;
    assign O_sram_oe_n   = oe_n_q;
    assign O_sram_ub_n   = ub_n_q;
    assign O_sram_lb_n   = lb_n_q;
    assign O_sram_dat    = {wdat_q, wdat_q};
    assign O_sram_dat_oe = dat_oe_q;
    assign wb.ACK_O      = ack_q;
    assign wb.DAT_O      = dat_o_q;

endmodule
